// File: rtl/alu_control_mc.sv
// ALU control decoder with a multi-cycle unsigned multiply/divide sequencer.
// Results land in hi/lo only on completion; mfhi/mflo read them through move_data.
module alu_control_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       alu_input,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       alu_output,
    output logic             illegal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] move_data,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0]   opnd_reg, opnd_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;

    always_comb begin
        alu_output = 4'b1111;
        illegal    = 1'b0;
        case (alu_input)
            2'b00: alu_output = 4'b0010;
            2'b01: alu_output = 4'b0110;
            2'b10: begin
                case (funct)
                    F_ADD:           alu_output = 4'b0010;
                    F_SUB:           alu_output = 4'b0110;
                    F_AND:           alu_output = 4'b0000;
                    F_OR:            alu_output = 4'b0001;
                    F_SLT:           alu_output = 4'b0111;
                    F_NOR:           alu_output = 4'b1100;
                    F_MFHI:          alu_output = 4'b1000;
                    F_MFLO:          alu_output = 4'b1001;
                    F_MULTU, F_DIVU: alu_output = 4'b1111;
                    default:         illegal    = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

    assign move_data = (funct == F_MFHI) ? hi_reg : lo_reg;
    assign busy      = (state_reg == MUL) || (state_reg == DIV);
    assign done      = (state_reg == DONE);
    assign hi        = hi_reg;
    assign lo        = lo_reg;
    assign stall     = busy && (alu_input == 2'b10) &&
                       ((funct == F_MFHI) || (funct == F_MFLO) ||
                        (funct == F_MULTU) || (funct == F_DIVU));

    // acc_reg holds {partial_hi, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_mul;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] acc_div;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                    (acc_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        acc_mul   = {mul_sum, acc_reg[WIDTH-1:1]};
        rem_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        diff      = {1'b0, rem_shift} - {2'b00, opnd_reg};
        if (!diff[WIDTH+1])
            acc_div = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
        else
            acc_div = {rem_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end

    logic accept;
    assign accept = ((state_reg == IDLE) || (state_reg == DONE)) && start &&
                    (alu_input == 2'b10) && ((funct == F_MULTU) || (funct == F_DIVU));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        opnd_next  = opnd_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept) begin
                    cnt_next = '0;
                    if (funct == F_MULTU) begin
                        state_next = MUL;
                        acc_next   = {{WIDTH{1'b0}}, b};
                        opnd_next  = a;
                    end else if (b == '0) begin
                        // Divide by zero skips iteration entirely.
                        state_next = DONE;
                        lo_next    = '1;
                        hi_next    = a;
                    end else begin
                        state_next = DIV;
                        acc_next   = {{WIDTH{1'b0}}, a};
                        opnd_next  = b;
                    end
                end
            end
            MUL: begin
                acc_next = acc_mul;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                    hi_next    = acc_mul[2*WIDTH-1:WIDTH];
                    lo_next    = acc_mul[WIDTH-1:0];
                end
            end
            DIV: begin
                acc_next = acc_div;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                    hi_next    = acc_div[2*WIDTH-1:WIDTH];
                    lo_next    = acc_div[WIDTH-1:0];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            opnd_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            opnd_reg  <= opnd_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode sweep, multu/divu timing and results,
// busy-time start rejection, back-to-back ops and asynchronous reset mid-operation.
module tb_alu_control_mc;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [1:0]       alu_input;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a, b;
    logic [3:0]       alu_output;
    logic             illegal, busy, done, stall;
    logic [WIDTH-1:0] hi, lo, move_data;

    int checks = 0;
    int errors = 0;

    alu_control_mc #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_input(alu_input),
        .funct(funct), .a(a), .b(b), .alu_output(alu_output), .illegal(illegal),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .move_data(move_data),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode table: returns {illegal, alu_output}.
    function automatic logic [4:0] exp_dec(input logic [1:0] op, input logic [5:0] f);
        case (op)
            2'b00: return 5'b0_0010;
            2'b01: return 5'b0_0110;
            2'b11: return 5'b1_1111;
            default: begin
                case (f)
                    6'b100000: return 5'b0_0010;
                    6'b100010: return 5'b0_0110;
                    6'b100100: return 5'b0_0000;
                    6'b100101: return 5'b0_0001;
                    6'b101010: return 5'b0_0111;
                    6'b100111: return 5'b0_1100;
                    6'b010000: return 5'b0_1000;
                    6'b010010: return 5'b0_1001;
                    6'b011001: return 5'b0_1111;
                    6'b011011: return 5'b0_1111;
                    default:   return 5'b1_1111;
                endcase
            end
        endcase
    endfunction

    // Called at a falling edge: presents the op for one rising edge, then clears inputs.
    task automatic issue(input logic [5:0] f, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        start = 1'b1; alu_input = 2'b10; funct = f; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; alu_input = 2'b00; funct = 6'd0;
    endtask

    task automatic run_busy(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_nodone"}, done, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_input = 2'b00; funct = 6'd0; a = '0; b = '0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        // Decode sweep while still in reset: decode must ignore reset.
        for (int op = 0; op < 4; op++) begin
            for (int f = 0; f < 64; f++) begin
                alu_input = op[1:0]; funct = f[5:0];
                #1;
                chk($sformatf("dec_%0d_%02h", op, f), {illegal, alu_output}, exp_dec(op[1:0], f[5:0]));
            end
        end
        $display("decode sweep: 256 vectors");
        alu_input = 2'b00; funct = 6'd0;

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        // multu FFFFFFFF * 2 with a rejected start and mflo stall while busy.
        issue(6'b011001, 32'hFFFF_FFFF, 32'h0000_0002);
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            chk("mul_busy", busy, 1'b1);
            chk("mul_nodone", done, 1'b0);
            if (i == 3) begin
                start = 1'b1; alu_input = 2'b10; funct = 6'b011001; a = 32'd3; b = 32'd3;
                #1;
                chk("stall_multu", stall, 1'b1);
            end else if (i == 4) begin
                start = 1'b0; funct = 6'b010010;
                #1;
                chk("stall_mflo", stall, 1'b1);
                chk("mflo_busy_data", move_data, 32'h0);
            end else if (i == 5) begin
                alu_input = 2'b00; funct = 6'd0;
                #1;
                chk("stall_off", stall, 1'b0);
            end else if (i == 10) begin
                chk("mul_hi_hold", hi, 32'h0);
                chk("mul_lo_hold", lo, 32'h0);
            end
        end
        @(negedge clk);
        chk("mul_done", done, 1'b1);
        chk("mul_done_busy", busy, 1'b0);
        chk("mul_hi", hi, 32'h0000_0001);
        chk("mul_lo", lo, 32'hFFFF_FFFE);
        $display("multu FFFFFFFF*00000002 -> hi=%h lo=%h", hi, lo);
        @(negedge clk);
        chk("mul_done_pulse", done, 1'b0);
        alu_input = 2'b10; funct = 6'b010000;
        #1;
        chk("mfhi_data", move_data, 32'h0000_0001);
        chk("mfhi_nostall", stall, 1'b0);
        funct = 6'b010010;
        #1;
        chk("mflo_data", move_data, 32'hFFFF_FFFE);
        alu_input = 2'b00; funct = 6'd0;

        // divu 100 / 7
        @(negedge clk);
        issue(6'b011011, 32'd100, 32'd7);
        run_busy(32, "div");
        @(negedge clk);
        chk("div_done", done, 1'b1);
        chk("div_lo", lo, 32'd14);
        chk("div_hi", hi, 32'd2);
        $display("divu 100/7 -> hi=%0d lo=%0d", hi, lo);

        // divu by zero: done on the very next cycle, never busy.
        @(negedge clk);
        issue(6'b011011, 32'h0000_ABCD, 32'h0);
        @(negedge clk);
        chk("dz_done", done, 1'b1);
        chk("dz_busy", busy, 1'b0);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_hi", hi, 32'h0000_ABCD);
        $display("divu ABCD/0 -> hi=%h lo=%h", hi, lo);
        @(negedge clk);
        chk("dz_after_done", done, 1'b0);
        chk("dz_after_busy", busy, 1'b0);

        // Back-to-back: divu accepted in the multu DONE cycle.
        issue(6'b011001, 32'h0001_0000, 32'h0001_0000);
        run_busy(32, "b2b_mul");
        @(negedge clk);
        chk("b2b_mul_done", done, 1'b1);
        chk("b2b_mul_hi", hi, 32'h1);
        chk("b2b_mul_lo", lo, 32'h0);
        $display("multu 10000*10000 -> hi=%h lo=%h", hi, lo);
        issue(6'b011011, 32'd1000, 32'd10);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("b2b_div_busy", busy, 1'b1);
            chk("b2b_div_nodone", done, 1'b0);
            chk("b2b_hold_hi", hi, 32'h1);
            chk("b2b_hold_lo", lo, 32'h0);
        end
        @(negedge clk);
        chk("b2b_div_done", done, 1'b1);
        chk("b2b_div_lo", lo, 32'd100);
        chk("b2b_div_hi", hi, 32'd0);
        $display("divu 1000/10 -> hi=%0d lo=%0d", hi, lo);
        @(negedge clk);
        chk("b2b_single_pulse", done, 1'b0);

        // Asynchronous reset at busy cycle 10 of a multu.
        issue(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_busy(10, "rst_mul");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_hi", hi, 32'h0);
        chk("arst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("arst_no_done", done, 1'b0);
            chk("arst_no_busy", busy, 1'b0);
        end
        chk("arst_hi_end", hi, 32'h0);
        chk("arst_lo_end", lo, 32'h0);
        $display("reset mid-multu -> hi=%h lo=%h", hi, lo);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
